// File: rtl/charlie_scanner.sv
// charlie_scanner: charlieplexed LED-matrix scan engine with a double-buffered frame store.
// Latency: pin_oe/pin_out are registered, one cycle behind the row/div/active state; frame_done flags the wrap cycle.
// Backpressure: frame_ready stays low while a shadow frame waits; frame_valid is ignored until the next frame wrap.
//
// Optional feature: define CHARLIE_DEADTIME_EN to blank every pin for the first DEAD_CYCLES cycles of each row slot.
//
// Ports:
//   CLK          system clock, all state on the rising edge
//   RST          asynchronous active-low reset
//   frame_data   new pattern, bit r*(NPINS-1)+c = LED at row r, column slot c
//   frame_valid  frame_data offered
//   frame_ready  shadow buffer empty (registered)
//   frame_done   one-cycle pulse on the frame wrap cycle (row NPINS-1 -> 0)
//   pin_oe       per-pin drive enable (0 = Hi-Z)
//   pin_out      per-pin level, meaningful where pin_oe = 1
module charlie_scanner #(
  parameter int NPINS       = 8,
  parameter int SCAN_DIV    = 1000,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NPINS*(NPINS-1)-1:0]     frame_data,
  input  logic                           frame_valid,
  output logic                           frame_ready,
  output logic                           frame_done,
  output logic [NPINS-1:0]               pin_oe,
  output logic [NPINS-1:0]               pin_out
);

  localparam int W  = NPINS * (NPINS - 1);
  localparam int RW = (NPINS > 2) ? $clog2(NPINS) : 1;
  localparam int DW = $clog2(SCAN_DIV);

  localparam logic [RW-1:0] ROW_LAST = RW'(NPINS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  // Elaboration-time guard on the parameter ranges the scan logic relies on.
  if (NPINS < 2 || SCAN_DIV < 2 || DEAD_CYCLES >= SCAN_DIV) begin : g_bad_params
    $error("charlie_scanner: illegal NPINS/SCAN_DIV/DEAD_CYCLES combination");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DW-1:0]    div_q, div_d;
  logic [RW-1:0]    row_q, row_d;
  logic [W-1:0]     active_q, active_d;
  logic [W-1:0]     shadow_q, shadow_d;
  logic             shadow_full_q, shadow_full_d;
  logic             frame_ready_q;
  logic             frame_done_q, frame_done_d;
  logic [NPINS-1:0] pin_oe_q, pin_oe_d;
  logic [NPINS-1:0] pin_out_q, pin_out_d;

  logic div_wrap;
  logic frame_wrap;
  logic load;

  // ---------------------------------------------------------------------------
  // Scan timing and frame store
  // ---------------------------------------------------------------------------
  always_comb begin
    div_wrap      = (div_q == DIV_LAST);
    frame_wrap    = div_wrap && (row_q == ROW_LAST);
    load          = frame_valid && frame_ready_q;

    div_d         = div_wrap ? '0 : div_q + 1'b1;
    row_d         = row_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;

    if (div_wrap) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end

    // Swap only at the frame boundary so a pattern is never torn mid-frame.
    if (frame_wrap && shadow_full_q) begin
      active_d      = shadow_q;
      shadow_full_d = 1'b0;
    end

    // frame_ready_q mirrors !shadow_full_q, so a load can never coincide with a
    // swap; a load on a wrap edge with an empty shadow lands in the shadow and
    // waits for the following frame.
    if (load) begin
      shadow_d      = frame_data;
      shadow_full_d = 1'b1;
    end

    // Registered from the next state so the pulse lines up with the wrap cycle.
    frame_done_d = (div_d == DIV_LAST) && (row_d == ROW_LAST);
  end

  // ---------------------------------------------------------------------------
  // Pin pattern for the current row
  // ---------------------------------------------------------------------------
  // Row r drives its own pin high; column slot c maps to pin c below the row
  // pin and to pin c+1 above it, skipping the row pin. Unlit LEDs leave their
  // column pin Hi-Z (pin_out stays 0 for all column pins).
  always_comb begin
    pin_oe_d  = '0;
    pin_out_d = '0;
    for (int r = 0; r < NPINS; r++) begin
      if (row_q == RW'(r)) begin
        pin_oe_d[r]  = 1'b1;
        pin_out_d[r] = 1'b1;
        for (int c = 0; c < NPINS - 1; c++) begin
          if (c < r) begin
            pin_oe_d[c] = active_q[r*(NPINS-1)+c];
          end else begin
            pin_oe_d[c+1] = active_q[r*(NPINS-1)+c];
          end
        end
      end
    end
`ifdef CHARLIE_DEADTIME_EN
    // Blank all pins at the head of each slot to kill ghosting on row changes.
    if (div_q < DW'(DEAD_CYCLES)) begin
      pin_oe_d  = '0;
      pin_out_d = '0;
    end
`else
    // Row pattern is driven for the whole slot; DEAD_CYCLES has no effect.
`endif
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_q         <= '0;
      row_q         <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      frame_ready_q <= 1'b1;
      frame_done_q  <= 1'b0;
      pin_oe_q      <= '0;
      pin_out_q     <= '0;
    end else begin
      div_q         <= div_d;
      row_q         <= row_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      frame_ready_q <= !shadow_full_d;
      frame_done_q  <= frame_done_d;
      pin_oe_q      <= pin_oe_d;
      pin_out_q     <= pin_out_d;
    end
  end

  assign frame_ready = frame_ready_q;
  assign frame_done  = frame_done_q;
  assign pin_oe      = pin_oe_q;
  assign pin_out     = pin_out_q;

endmodule

// File: doc/charlie_scanner.md
Name: charlie_scanner

Overview:
- Parametrised charlieplexed LED-matrix scan engine; successor to the fixed 8-pin, 56-LED matrix driver.
- Drives NPINS tristate-able pins to light up to NPINS*(NPINS-1) LEDs, one anode row per time slot.
- Double-buffered frame store with a valid/ready load port, so patterns change without tearing.
- The top level owns the inout pads; this block outputs per-pin enable and level.

Parameters:
- NPINS, 8, number of charlieplex pins (>=2); pattern width W = NPINS*(NPINS-1).
- SCAN_DIV, 1000, CLK cycles per row slot (>=2).
- DEAD_CYCLES, 4, blanking cycles at the start of each slot (< SCAN_DIV); used only with CHARLIE_DEADTIME_EN.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- frame_data  in  W  new pattern; bit r*(NPINS-1)+c = LED (row r, column slot c).
- frame_valid  in  1  frame_data offered.
- frame_ready  out  1  shadow buffer empty; a load is accepted when valid&&ready at a CLK edge.
- frame_done  out  1  one-cycle pulse at each frame wrap (row NPINS-1 -> 0).
- pin_oe  out  NPINS  1 = drive the pin, 0 = Hi-Z.
- pin_out  out  NPINS  level driven when pin_oe=1.

Behaviour:
- Reset (RST=0, async) sets:
  - pin_oe=0, pin_out=0, frame_done=0, frame_ready=1.
  - Active and shadow buffers =0, shadow_full=0, row=0, div=0.
- Divider: div counts 0..SCAN_DIV-1, then wraps. On wrap, row increments mod NPINS.
- Frame wrap (div wrap with row=NPINS-1):
  - frame_done=1 for that one cycle.
  - If shadow_full, active<=shadow and shadow_full<=0.
- Load: valid&&ready sets shadow<=frame_data and shadow_full<=1.
  - frame_ready = !shadow_full, registered, so it falls the cycle after acceptance and rises the cycle after a swap.
  - With ready=0, frame_valid is ignored; the producer holds data (standard valid/ready).
  - A load accepted on the same edge as a frame wrap with an empty shadow goes to the shadow and is displayed from the next frame. It never goes directly to active.
- Column mapping for row r, slot c in 0..NPINS-2: pin p = c if c<r, else c+1 (row pin skipped).
- Outputs (registered, 1-cycle latency from the row/div/active state):
  - Row pin: pin_oe[r]=1, pin_out[r]=1.
  - Each column pin p: pin_oe[p]=active bit for (r,c), pin_out[p]=0.
- Unlit LEDs leave their column pin Hi-Z. The all-zero pattern drives only the row pin.
- Reset mid-frame: outputs go to 0 immediately. After release, scanning restarts at row 0, div 0, and any pending shadow frame is lost.

Optional Feature:
- Macro: CHARLIE_DEADTIME_EN.
- Defined: while div < DEAD_CYCLES, pin_oe=0 and pin_out=0 (all pins Hi-Z), then the normal row pattern for the rest of the slot. This removes ghosting on row transitions.
- Undefined: the row pattern is driven for the whole slot; DEAD_CYCLES is unused.

Test Plan (NPINS=8, SCAN_DIV=4, W=56):
- Reset: RST low then release -> pin_oe=0, pin_out=0, frame_ready=1. From 1 cycle after release: pin_oe=0x01, pin_out=0x01 (row 0, blank pattern).
- Load bit 7 (row 1, c0): valid pulse at cycle 2 -> frame_ready low next cycle. At cycle 32 frame_done=1 and the swap happens; frame_ready=1 at cycle 33. During row 1 of the next frame: pin_oe=0x03, pin_out=0x02.
- Mapping: load bit 24 (row 3, c3 -> pin 4) -> during row 3: pin_oe=0x18, pin_out=0x08. Other rows show only their row bit.
- Backpressure: offer A then B with valid held high -> A accepted, B held with ready=0 until frame_done. B is accepted the cycle after ready rises and is displayed one frame after A.
- Reset mid-frame: drop RST during row 5 with a shadow frame pending -> outputs 0 asynchronously. After release: row 0, blank pattern, frame_ready=1.
- CHARLIE_DEADTIME_EN with DEAD_CYCLES=1 -> first cycle of each 4-cycle slot pin_oe=0x00; remaining 3 cycles show the row pattern.
